// File: rtl/apb_pkg.sv
// Shared types for the APB multi-slave bridge: FSM state encoding, response payload
// and the slave-index width helper.
package apb_pkg;

  localparam int unsigned APB_MAX_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Sized for the widest supported bus; the bridge uses the low DATA_WIDTH bits.
  typedef struct packed {
    logic [APB_MAX_DATA_WIDTH-1:0] rdata;
    logic                          err;
  } apb_rsp_t;

  function automatic int unsigned sel_bits(input int unsigned num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles; expired_o flags that the next enabled cycle is the last one allowed.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic clear_i,
  output logic expired_o
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_c;
    assign unused_c  = ^{clk_i, rst_ni, enable_i, clear_i};
    assign expired_o = 1'b0;
  end else begin : g_on
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             expired_q;

    // Saturating count so a stuck enable can never wrap back to zero.
    always_comb begin
      count_d = count_q;
      if (clear_i) begin
        count_d = '0;
      end else if (enable_i && (count_q != LIMIT)) begin
        count_d = count_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        count_q   <= '0;
        expired_q <= 1'b0;
      end else begin
        count_q   <= count_d;
        expired_q <= (count_d == LAST);
      end
    end

    assign expired_o = expired_q;
  end

endmodule

// File: rtl/apb_multi_slave_bridge.sv
// APB master bridge: valid/ready command port in, one-shot response out, NUM_SLAVES PSEL lines
// with per-slave ready/error, wait-state timeout and back-to-back transfers.
module apb_multi_slave_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             pclk,
  input  logic                             preset_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int unsigned SEL_BITS = sel_bits(NUM_SLAVES);

  apb_state_e              state_q;
  logic [NUM_SLAVES-1:0]   psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic                    rsp_valid_q;
  apb_rsp_t                rsp_q;

  logic [SEL_BITS-1:0]     slave_idx_c;
  logic [SEL_BITS-1:0]     req_idx_c;
  logic [NUM_SLAVES-1:0]   req_psel_c;
  logic                    sel_ready_c;
  logic                    sel_err_c;
  logic [DATA_WIDTH-1:0]   sel_rdata_c;
  logic                    decode_err_c;
  logic                    in_access_c;
  logic                    tmr_en_c;
  logic                    tmr_expired;
  logic                    timeout_c;
  logic                    done_c;
  logic                    accept_c;
  logic                    rsp_err_c;
  logic                    unused_rsp_c;

  assign slave_idx_c = paddr_q[ADDR_WIDTH-1 -: SEL_BITS];
  assign req_idx_c   = req_addr[ADDR_WIDTH-1 -: SEL_BITS];

  // Route the addressed slave's handshake back, and pre-decode PSEL for the incoming command.
  always_comb begin : slave_mux
    sel_ready_c = 1'b0;
    sel_err_c   = 1'b0;
    sel_rdata_c = '0;
    req_psel_c  = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (slave_idx_c == SEL_BITS'(i)) begin
        sel_ready_c = pready[i];
        sel_err_c   = pslverr[i];
        sel_rdata_c = prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
      req_psel_c[i] = (req_idx_c == SEL_BITS'(i));
    end
  end

  // Only a non-power-of-two slave count leaves index values with no PSEL line.
  if (NUM_SLAVES < (2 ** SEL_BITS)) begin : g_partial_decode
    assign decode_err_c = (slave_idx_c >= SEL_BITS'(NUM_SLAVES));
  end else begin : g_full_decode
    assign decode_err_c = 1'b0;
  end

  assign in_access_c = (state_q == ACCESS);
  assign tmr_en_c    = in_access_c & ~sel_ready_c & ~decode_err_c;
  assign timeout_c   = tmr_en_c & tmr_expired;
  assign done_c      = in_access_c & (sel_ready_c | decode_err_c | timeout_c);
  assign rsp_err_c   = decode_err_c | sel_err_c | timeout_c;

  // Ready in IDLE and in the completing ACCESS cycle, which is what allows back-to-back transfers.
  assign req_ready = preset_n & ((state_q == IDLE) | done_c);
  assign accept_c  = req_valid & req_ready;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i    (pclk),
    .rst_ni   (preset_n),
    .enable_i (tmr_en_c),
    .clear_i  (accept_c),
    .expired_o(tmr_expired)
  );

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      rsp_valid_q <= done_c;
      rsp_q.err   <= done_c & rsp_err_c;
      rsp_q.rdata <= (done_c & ~pwrite_q & ~rsp_err_c) ? APB_MAX_DATA_WIDTH'(sel_rdata_c) : '0;

      if (accept_c) begin
        paddr_q   <= req_addr;
        pwdata_q  <= req_wdata;
        pwrite_q  <= req_write;
        psel_q    <= req_psel_c;
        penable_q <= 1'b0;
        state_q   <= SETUP;
      end else begin
        unique case (state_q)
          SETUP: begin
            penable_q <= 1'b1;
            state_q   <= ACCESS;
          end
          ACCESS: begin
            if (done_c) begin
              penable_q <= 1'b0;
              psel_q    <= '0;
              state_q   <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign unused_rsp_c = ^rsp_q.rdata;

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_q.err;
  assign rsp_rdata = rsp_q.rdata[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_apb_multi_slave_bridge.sv
// Bench for apb_multi_slave_bridge: a transaction-level timeline model predicts every cycle of
// bus and response activity for directed and random transfers, and the DUT is compared per cycle.
module tb_apb_multi_slave_bridge;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int NS   = 4;
  localparam int TO   = 16;
  localparam int NCYC = 2048;

  logic           pclk = 1'b0;
  logic           preset_n;
  logic           req_valid, req_ready, req_write;
  logic [AW-1:0]  req_addr;
  logic [DW-1:0]  req_wdata;
  logic           rsp_valid, rsp_err;
  logic [DW-1:0]  rsp_rdata;
  logic [NS-1:0]  psel;
  logic           penable, pwrite;
  logic [AW-1:0]  paddr;
  logic [DW-1:0]  pwdata;
  logic [NS-1:0]  pready, pslverr;
  logic [NS*DW-1:0] prdata;

  always #5 pclk = ~pclk;

  apb_multi_slave_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  // Per-cycle stimulus
  logic          d_rstn   [NCYC];
  logic          d_valid  [NCYC];
  logic          d_write  [NCYC];
  logic [15:0]   d_addr   [NCYC];
  logic [15:0]   d_wdata  [NCYC];
  logic [3:0]    d_pready [NCYC];
  logic [3:0]    d_pslverr[NCYC];
  logic [63:0]   d_prdata [NCYC];
  // Per-cycle expectations derived from the transaction timeline
  logic          b_on     [NCYC];
  logic          b_pen    [NCYC];
  logic          b_busy   [NCYC];
  logic          b_write  [NCYC];
  logic [15:0]   b_addr   [NCYC];
  logic [15:0]   b_wdata  [NCYC];
  logic          e_rv     [NCYC];
  logic          e_err    [NCYC];
  logic [15:0]   e_rdata  [NCYC];

  int free_c, last_a, last_c, rst_cyc, end_cyc;
  logic [15:0] post_addr;
  int total = 0;
  int bad   = 0;

  logic        cur_write;
  logic [15:0] cur_addr, cur_wdata;

  task automatic check(input string name, input int t, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, t, act, exp);
    end
  endtask

  // Place one transfer on the timeline: offered at cycle o, accepted as soon as the bridge can,
  // w wait states on the addressed slave (w >= TO means the slave never answers).
  task automatic sched(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] rdata, input logic serr, input int w, input int o,
                       input bit abort);
    int a, c, s, last;
    logic e;
    a = (o > free_c) ? o : free_c;
    s = int'(addr[15:14]);
    for (int t = o; t <= a; t++) begin
      d_valid[t] = 1'b1; d_write[t] = wr; d_addr[t] = addr; d_wdata[t] = wdata;
    end
    c    = a + 2 + ((w >= TO) ? TO - 1 : w);
    last = abort ? a + 3 : c;
    for (int t = a + 1; t <= last; t++) begin
      b_on[t] = 1'b1; b_pen[t] = (t >= a + 2); b_busy[t] = (t < last) || abort;
      b_write[t] = wr; b_addr[t] = addr; b_wdata[t] = wdata;
    end
    for (int t = a + 2; t <= last; t++) d_pready[t][s] = 1'b0;
    if (abort) begin
      d_rstn[last] = 1'b0;
      free_c = last + 1;
    end else begin
      d_pready[c][s]          = (w < TO);
      d_pslverr[c][s]         = serr;
      d_prdata[c][s*16 +: 16] = rdata;
      e            = (w >= TO) || serr;
      e_rv[c + 1]    = 1'b1;
      e_err[c + 1]   = e;
      e_rdata[c + 1] = (!wr && !e) ? rdata : 16'h0;
      free_c = c;
    end
    last_a = a;
    last_c = last;
  endtask

  task automatic build();
    int w, o;
    for (int t = 0; t < NCYC; t++) begin
      d_rstn[t] = (t >= 3); d_valid[t] = 1'b0; d_write[t] = 1'($urandom);
      d_addr[t] = 16'($urandom); d_wdata[t] = 16'($urandom);
      d_pready[t] = 4'($urandom); d_pslverr[t] = 4'($urandom);
      d_prdata[t] = {$urandom, $urandom};
      b_on[t] = 1'b0; b_pen[t] = 1'b0; b_busy[t] = 1'b0; b_write[t] = 1'b0;
      b_addr[t] = 16'h0; b_wdata[t] = 16'h0;
      e_rv[t] = 1'b0; e_err[t] = 1'b0; e_rdata[t] = 16'h0;
    end
    free_c = 3;
    sched(1'b1, 16'h4010, 16'hBEEF, 16'h0000, 1'b0, 0,   5,  1'b0);
    sched(1'b0, 16'hC004, 16'h0000, 16'h1234, 1'b0, 2,   12, 1'b0);
    sched(1'b1, 16'h0100, 16'h1111, 16'h0000, 1'b0, 0,   20, 1'b0);
    sched(1'b1, 16'h8020, 16'h2222, 16'h0000, 1'b0, 0,   21, 1'b0);
    sched(1'b0, 16'h8000, 16'h0000, 16'h5555, 1'b0, 100, 30, 1'b0);
    sched(1'b0, 16'h4002, 16'h0000, 16'hAAAA, 1'b1, 1,   52, 1'b0);
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 7))
        0, 1:    w = 0;
        2:       w = 1;
        3:       w = 2;
        4:       w = 3;
        5:       w = 5;
        6:       w = 20;
        default: w = 0;
      endcase
      o = last_a + 1 + int'($urandom_range(0, 32'(last_c - last_a + 3)));
      sched(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 3) == 0), w, o, 1'b0);
    end
    o = last_a + 1 + int'($urandom_range(0, 4));
    sched(1'b0, 16'h4444, 16'h0, 16'h7777, 1'b0, 10, o, 1'b1);
    rst_cyc   = last_c;
    post_addr = 16'h8ABC;
    sched(1'b1, post_addr, 16'h3C3C, 16'h0, 1'b0, 1, rst_cyc + 1, 1'b0);
    end_cyc = last_c + 4;
  endtask

  task automatic compare(input int t);
    logic [3:0] exp_psel;
    if (t == 0 || !d_rstn[t-1]) begin
      cur_write = 1'b0; cur_addr = 16'h0; cur_wdata = 16'h0;
    end else if (b_on[t]) begin
      cur_write = b_write[t]; cur_addr = b_addr[t]; cur_wdata = b_wdata[t];
    end
    exp_psel = b_on[t] ? (4'b0001 << b_addr[t][15:14]) : 4'b0000;
    check("psel",      t, 64'(psel),      64'(exp_psel));
    check("penable",   t, 64'(penable),   64'(b_on[t] && b_pen[t]));
    check("pwrite",    t, 64'(pwrite),    64'(cur_write));
    check("paddr",     t, 64'(paddr),     64'(cur_addr));
    check("pwdata",    t, 64'(pwdata),    64'(cur_wdata));
    check("req_ready", t, 64'(req_ready), 64'(d_rstn[t] && !b_busy[t]));
    check("rsp_valid", t, 64'(rsp_valid), 64'(e_rv[t]));
    if (e_rv[t]) begin
      check("rsp_err",   t, 64'(rsp_err),   64'(e_err[t]));
      check("rsp_rdata", t, 64'(rsp_rdata), 64'(e_rdata[t]));
    end
    // Hand-computed pins for the directed scenarios
    case (t)
      1: begin
        check("lit_rst_ready", t, 64'(req_ready), 64'(0));
        check("lit_rst_psel",  t, 64'(psel),      64'(0));
      end
      3:  check("lit_idle_ready", t, 64'(req_ready), 64'(1));
      6:  check("lit_t1_psel",    t, 64'(psel),      64'(4'b0010));
      7: begin
        check("lit_t1_penable", t, 64'(penable), 64'(1));
        check("lit_t1_pwdata",  t, 64'(pwdata),  64'(16'hBEEF));
      end
      8: begin
        check("lit_t1_rsp_valid", t, 64'(rsp_valid), 64'(1));
        check("lit_t1_rsp_err",   t, 64'(rsp_err),   64'(0));
      end
      16: check("lit_t2_no_early_rsp", t, 64'(rsp_valid), 64'(0));
      17: begin
        check("lit_t2_rsp_valid", t, 64'(rsp_valid), 64'(1));
        check("lit_t2_rdata",     t, 64'(rsp_rdata), 64'(16'h1234));
      end
      22: check("lit_t3_ready_b2b", t, 64'(req_ready), 64'(1));
      23: begin
        check("lit_t3_psel2",   t, 64'(psel),    64'(4'b0100));
        check("lit_t3_penable", t, 64'(penable), 64'(0));
      end
      47: check("lit_t4_last_access", t, 64'(penable), 64'(1));
      48: begin
        check("lit_t4_err",   t, 64'(rsp_err),   64'(1));
        check("lit_t4_rdata", t, 64'(rsp_rdata), 64'(0));
        check("lit_t4_psel",  t, 64'(psel),      64'(0));
      end
      56: begin
        check("lit_t5_err",   t, 64'(rsp_err),   64'(1));
        check("lit_t5_rdata", t, 64'(rsp_rdata), 64'(0));
      end
      default: ;
    endcase
    if (t == rst_cyc + 1) begin
      check("lit_rst_psel0",    t, 64'(psel),      64'(0));
      check("lit_rst_penable0", t, 64'(penable),   64'(0));
      check("lit_rst_norsp",    t, 64'(rsp_valid), 64'(0));
      check("lit_rst_ready1",   t, 64'(req_ready), 64'(1));
    end
    if (t == rst_cyc + 2) begin
      check("lit_post_psel", t, 64'(psel), 64'(4'b0001 << post_addr[15:14]));
    end
  endtask

  initial begin
    preset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    pready = '0; pslverr = '0; prdata = '0;
    cur_write = 1'b0; cur_addr = 16'h0; cur_wdata = 16'h0;
    build();
    if (end_cyc >= NCYC) begin
      bad++;
      $display("FAIL schedule_overflow end=%0d limit=%0d", end_cyc, NCYC);
      end_cyc = NCYC - 1;
    end
    for (int t = 0; t <= end_cyc; t++) begin
      @(posedge pclk);
      #1;
      preset_n  = d_rstn[t];
      req_valid = d_valid[t];
      req_write = d_write[t];
      req_addr  = d_addr[t];
      req_wdata = d_wdata[t];
      pready    = d_pready[t];
      pslverr   = d_pslverr[t];
      prdata    = d_prdata[t];
      @(negedge pclk);
      compare(t);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
